// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter_if
// Brief    : Bundle of WB, MDU, decode-hazard and register-file write signals
//            around the register-file write arbiter.
// Revision : 1.0
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             regwrite_wb;
    logic [4:0]       regaddr_wb;
    logic [WIDTH-1:0] result_wb;
    logic             mdu_valid;
    logic [4:0]       mdu_addr;
    logic [WIDTH-1:0] mdu_data;
    logic             mdu_ready;
    logic [4:0]       rs_decode;
    logic [4:0]       rt_decode;
    logic             pending_hit_decode;
    logic             rf_we;
    logic [4:0]       rf_addr;
    logic [WIDTH-1:0] rf_data;
    logic             starve_stall;

    // master: pipeline/MDU side driving requests; slave: the arbiter
    modport master (
        output regwrite_wb, regaddr_wb, result_wb,
        output mdu_valid, mdu_addr, mdu_data,
        output rs_decode, rt_decode,
        input  mdu_ready, pending_hit_decode,
        input  rf_we, rf_addr, rf_data, starve_stall
    );

    modport slave (
        input  regwrite_wb, regaddr_wb, result_wb,
        input  mdu_valid, mdu_addr, mdu_data,
        input  rs_decode, rt_decode,
        output mdu_ready, pending_hit_decode,
        output rf_we, rf_addr, rf_data, starve_stall
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Shares the register-file write port between WB (always wins) and
//            an in-order MDU result buffer; flags decode hazards on buffered
//            destinations. Optional starvation guard: RF_ARB_STARVE_GUARD_EN.
// Revision : 1.0
// ============================================================================
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int WIDTH        = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rf_write_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [4:0]       r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_wb_write;
    logic w_ready;
    logic w_pop;
    logic w_push;
    logic w_hit;

    // A WB write to r0 is suppressed and leaves the port free for a drain
    assign w_wb_write = !rst && bus.regwrite_wb && (bus.regaddr_wb != 5'd0);
    assign w_ready    = !rst && (r_count != C_FULL);
    assign w_pop      = !rst && !w_wb_write && (r_count != '0);
    assign w_push     = bus.mdu_valid && w_ready && (bus.mdu_addr != 5'd0);

    assign bus.mdu_ready = w_ready;
    assign bus.rf_we     = w_wb_write | w_pop;
    assign bus.rf_addr   = w_wb_write ? bus.regaddr_wb : r_addr[r_head];
    assign bus.rf_data   = w_wb_write ? bus.result_wb  : r_data[r_head];

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] &&
                (((bus.rs_decode != 5'd0) && (r_addr[i] == bus.rs_decode)) ||
                 ((bus.rt_decode != 5'd0) && (r_addr[i] == bus.rt_decode)))) begin
                w_hit = 1'b1;
            end
        end
    end

    assign bus.pending_hit_decode = w_hit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity lives in r_valid/r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.mdu_addr;
            r_data[r_tail] <= bus.mdu_data;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] C_LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_age_next;
    logic             r_starve;

    always_comb begin
        w_age_next = r_age;
        if (w_pop || (r_count == '0)) begin
            w_age_next = '0;
        end else if (r_age != C_LIMIT) begin
            w_age_next = r_age + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_age    <= '0;
            r_starve <= 1'b0;
        end else begin
            r_age    <= w_age_next;
            r_starve <= (w_age_next == C_LIMIT);
        end
    end

    assign bus.starve_stall = r_starve;
`else
    assign bus.starve_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed vector table, starvation sequence and random traffic
//            against a queue-based reference model of rf_write_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rf_write_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.WIDTH(32)) bus ();

    rf_write_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ready;
        logic        hit;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rw, input logic [4:0] ra, input logic [31:0] rd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic we, input logic [4:0] addr, input logic [31:0] data,
                       input logic ready, input logic hit);
        vec_t v;
        v.rst = r;   v.rw = rw;  v.ra = ra;  v.rd = rd;
        v.mv = mv;   v.ma = ma;  v.md = md;  v.rs = rs;  v.rt = rt;
        v.we = we;   v.addr = addr; v.data = data; v.ready = ready; v.hit = hit;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rw, input logic [4:0] ra, input logic [31:0] rd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] rs, input logic [4:0] rt);
        rst             = r;
        bus.regwrite_wb = rw;
        bus.regaddr_wb  = ra;
        bus.result_wb   = rd;
        bus.mdu_valid   = mv;
        bus.mdu_addr    = ma;
        bus.mdu_data    = md;
        bus.rs_decode   = rs;
        bus.rt_decode   = rt;
    endtask

    // Reference model state: buffered {addr, data} in retirement order
    logic [36:0] q[$];
    int          age;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //   rst rw ra  rd       mv ma  md       rs  rt   we addr data     rdy hit
        add(1, 1, 3,  32'h33,   1, 4,  32'h44,  4,  0,   0, 0,  0,       0,  0);
        add(0, 1, 5,  32'h1234, 0, 0,  0,       0,  0,   1, 5,  32'h1234, 1, 0);
        add(0, 0, 0,  0,        1, 7,  32'hAAAA, 7, 0,   0, 0,  0,       1,  0);
        add(0, 0, 0,  0,        0, 0,  0,       7,  0,   1, 7,  32'hAAAA, 1, 1);
        add(0, 0, 0,  0,        0, 0,  0,       7,  0,   0, 0,  0,       1,  0);
        add(0, 1, 10, 32'h100,  1, 8,  32'h88,  0,  0,   1, 10, 32'h100, 1,  0);
        add(0, 1, 11, 32'h101,  1, 9,  32'h99,  0,  8,   1, 11, 32'h101, 1,  1);
        add(0, 1, 12, 32'h102,  1, 13, 32'h13,  0,  9,   1, 12, 32'h102, 0,  1);
        add(0, 0, 0,  0,        1, 13, 32'h13,  8,  9,   1, 8,  32'h88,  0,  1);
        add(0, 0, 0,  0,        0, 0,  0,       0,  9,   1, 9,  32'h99,  1,  1);
        add(0, 1, 0,  32'h55,   1, 0,  32'h66,  0,  0,   0, 0,  0,       1,  0);
        add(0, 0, 0,  0,        0, 0,  0,       0,  0,   0, 0,  0,       1,  0);
        add(0, 1, 1,  32'h1,    1, 20, 32'h20,  0,  0,   1, 1,  32'h1,   1,  0);
        add(0, 1, 2,  32'h2,    1, 21, 32'h21,  0,  0,   1, 2,  32'h2,   1,  0);
        add(1, 0, 0,  0,        0, 0,  0,       20, 0,   0, 0,  0,       0,  0);
        add(0, 0, 0,  0,        0, 0,  0,       20, 21,  0, 0,  0,       1,  0);
        add(0, 0, 0,  0,        0, 0,  0,       20, 21,  0, 0,  0,       1,  0);

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rw, tbl[i].ra, tbl[i].rd, tbl[i].mv, tbl[i].ma,
                  tbl[i].md, tbl[i].rs, tbl[i].rt);
            @(negedge clk);
            chk($sformatf("vec%0d rf_we", i), 32'(bus.rf_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("vec%0d rf_addr", i), 32'(bus.rf_addr), 32'(tbl[i].addr));
                chk($sformatf("vec%0d rf_data", i), bus.rf_data, tbl[i].data);
            end
            chk($sformatf("vec%0d mdu_ready", i), 32'(bus.mdu_ready), 32'(tbl[i].ready));
            chk($sformatf("vec%0d pending_hit", i), 32'(bus.pending_hit_decode), 32'(tbl[i].hit));
            chk($sformatf("vec%0d starve_stall", i), 32'(bus.starve_stall), 32'd0);
            @(posedge clk); #1;
        end

        // Starvation: one entry held behind continuous WB writes, then drained
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int k = 0; k <= 7; k++) begin
            logic exp_stall;
            if (k == 0)      drive(0, 1, 3, 32'h3, 1, 15, 32'hF00D, 15, 0);
            else if (k <= 6) drive(0, 1, 3, 32'h3, 0, 0,  0,        15, 0);
            else             drive(0, 0, 0, 0,     0, 0,  0,        15, 0);
            exp_stall = GUARD && (k >= 5) && (k <= 7);
            @(negedge clk);
            chk($sformatf("starve k%0d stall", k), 32'(bus.starve_stall), 32'(exp_stall));
            chk($sformatf("starve k%0d hit", k), 32'(bus.pending_hit_decode), 32'(k >= 1));
            if (k == 7) begin
                chk("starve drain we", 32'(bus.rf_we), 32'd1);
                chk("starve drain addr", 32'(bus.rf_addr), 32'd15);
                chk("starve drain data", bus.rf_data, 32'hF00D);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 15, 0);
        @(negedge clk);
        chk("starve release stall", 32'(bus.starve_stall), 32'd0);
        chk("starve release we", 32'(bus.rf_we), 32'd0);
        @(posedge clk); #1;

        // Random traffic against the queue model (buffer is empty, age 0 here)
        q.delete();
        age = 0;
        for (int c = 0; c < 400; c++) begin
            logic        r, rw, mv, wbw, e_we, e_rdy, e_hit, e_stall, popped;
            logic [4:0]  ra, ma, rs, rt, e_addr;
            logic [31:0] rd, md, e_data;
            r  = ($urandom_range(0, 63) == 0);
            rw = ($urandom_range(0, 3) != 0);
            ra = 5'($urandom_range(0, 7));
            rd = $urandom;
            mv = ($urandom_range(0, 1) == 1);
            ma = 5'($urandom_range(0, 7));
            md = $urandom;
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            drive(r, rw, ra, rd, mv, ma, md, rs, rt);

            wbw    = !r && rw && (ra != 5'd0);
            e_we   = !r && (wbw || q.size() > 0);
            e_addr = wbw ? ra : (q.size() > 0 ? q[0][36:32] : 5'd0);
            e_data = wbw ? rd : (q.size() > 0 ? q[0][31:0]  : 32'd0);
            e_rdy  = !r && (q.size() < DEPTH);
            e_hit  = 1'b0;
            if (!r) begin
                foreach (q[j]) begin
                    if ((rs != 0 && q[j][36:32] == rs) || (rt != 0 && q[j][36:32] == rt))
                        e_hit = 1'b1;
                end
            end
            e_stall = GUARD && (age == STARVE_LIMIT);

            @(negedge clk);
            chk($sformatf("rnd%0d rf_we", c), 32'(bus.rf_we), 32'(e_we));
            if (e_we) begin
                chk($sformatf("rnd%0d rf_addr", c), 32'(bus.rf_addr), 32'(e_addr));
                chk($sformatf("rnd%0d rf_data", c), bus.rf_data, e_data);
            end
            chk($sformatf("rnd%0d mdu_ready", c), 32'(bus.mdu_ready), 32'(e_rdy));
            chk($sformatf("rnd%0d pending_hit", c), 32'(bus.pending_hit_decode), 32'(e_hit));
            chk($sformatf("rnd%0d starve_stall", c), 32'(bus.starve_stall), 32'(e_stall));

            if (r) begin
                q.delete();
                age = 0;
            end else begin
                popped = !wbw && (q.size() > 0);
                if (popped || q.size() == 0) age = 0;
                else if (age < STARVE_LIMIT) age = age + 1;
                if (popped) void'(q.pop_front());
                if (mv && e_rdy && ma != 5'd0) q.push_back({ma, md});
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
